// File: rtl/sme_multi_if.sv
// ---------------------------------------------------------------------------
// sme_multi_if
// Bundles the character-load strobes and the search-result signals of the
// string-matching engine into one interface.
//
// Signals:
//   chardata    character input (DATA_W bits)
//   isstring    string-load strobe, one character per cycle
//   ispattern   pattern-load strobe, one character per cycle
//   find_all    0 = stop at first match, 1 = count every matching position
//   valid       one-cycle result strobe
//   match       at least one match found (qualified by valid)
//   match_index start index of the first match
//   match_count number of matching start positions
//   overflow    string or pattern exceeded its maximum length in this job
//
// Modports: master drives the strobes and reads results (the client),
//           slave is the engine side.
// ---------------------------------------------------------------------------
interface sme_multi_if #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DATA_W  = 8
);
    localparam int IW = $clog2(STR_MAX);
    localparam int CW = $clog2(STR_MAX + 1);

    logic [DATA_W-1:0] chardata;
    logic              isstring;
    logic              ispattern;
    logic              find_all;
    logic              valid;
    logic              match;
    logic [IW-1:0]     match_index;
    logic [CW-1:0]     match_count;
    logic              overflow;

    modport master (
        output chardata, isstring, ispattern, find_all,
        input  valid, match, match_index, match_count, overflow
    );

    modport slave (
        input  chardata, isstring, ispattern, find_all,
        output valid, match, match_index, match_count, overflow
    );
endinterface

// File: rtl/sme_multi.sv
// ---------------------------------------------------------------------------
// sme_multi
// String-matching engine. A string (up to STR_MAX characters) and then a
// pattern (up to PAT_MAX characters) are streamed in one character per
// cycle. The engine then scans the string one character compare per cycle,
// honouring '^' (start of string or after a space), '$' (end of string or
// before a space) and '.' (any character). Results are presented for one
// cycle with valid.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    sme_multi_if slave modport (load strobes in, results out)
// ---------------------------------------------------------------------------
module sme_multi #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DATA_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    sme_multi_if.slave  bus
);
    localparam int IW  = $clog2(STR_MAX);
    localparam int LW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int SW  = ((LW > PLW) ? LW : PLW) + 2;

    localparam logic [DATA_W-1:0] CH_CARET  = DATA_W'('h5E);
    localparam logic [DATA_W-1:0] CH_DOLLAR = DATA_W'('h24);
    localparam logic [DATA_W-1:0] CH_DOT    = DATA_W'('h2E);
    localparam logic [DATA_W-1:0] CH_SPACE  = DATA_W'('h20);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SEARCH,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] str [STR_MAX];
    logic [DATA_W-1:0] pat [PAT_MAX];
    logic [LW-1:0]     len;
    logic [PLW-1:0]    plen;
    // One spare bit: with a zero-length core the scan runs to p = len + 1.
    logic [LW:0]       p;
    logic [PLW-1:0]    k;
    logic [LW-1:0]     count;
    logic [IW-1:0]     first_idx;
    logic              overflow_q;
    logic              find_all_q;

    // Control strobes from the FSM to the datapath
    logic str_start, str_wr, pat_start, pat_wr;
    logic k_inc, p_adv, rec, job_clr;

    // Pattern decode and per-cycle compare results
    logic [PW-1:0]  pat_last;
    logic           anc_s, anc_e;
    logic [PLW-1:0] clen;
    logic [SW-1:0]  p_w, k_w, clen_w, len_w;
    logic [IW-1:0]  str_ci, str_prev, str_next;
    logic [PW-1:0]  pat_ci;
    logic           past_end, char_ok, step_ok, last_cmp;
    logic           start_ok, end_ok, hit;

    // Pattern decode and compare logic. The pattern is stable during SEARCH,
    // so the anchors and core length are derived combinationally. All
    // arithmetic is done at a common width SW so that position sums never
    // wrap; array indices are then narrowed. Out-of-range reads (p-1 at
    // p=0, p+clen at the end of the string) are always masked by the
    // preceding OR terms.
    always_comb begin
        pat_last = (plen == '0) ? '0 : PW'(plen - 1'b1);
        anc_s    = (plen != '0) && (pat[0] == CH_CARET);
        anc_e    = (plen != '0) && (pat[pat_last] == CH_DOLLAR);
        clen     = plen - PLW'(anc_s) - PLW'(anc_e);

        p_w      = SW'(p);
        k_w      = SW'(k);
        clen_w   = SW'(clen);
        len_w    = SW'(len);

        str_ci   = IW'(p_w + k_w);
        str_prev = IW'(p_w - SW'(1));
        str_next = IW'(p_w + clen_w);
        pat_ci   = PW'(k + PLW'(anc_s));

        past_end = (p_w + clen_w) > len_w;
        char_ok  = (pat[pat_ci] == CH_DOT) || (pat[pat_ci] == str[str_ci]);
        step_ok  = (clen == '0) || char_ok;
        last_cmp = (clen == '0) || ((k_w + SW'(1)) == clen_w);
        start_ok = !anc_s || (p == '0) || (str[str_prev] == CH_SPACE);
        end_ok   = !anc_e || ((p_w + clen_w) == len_w) || (str[str_next] == CH_SPACE);
        hit      = step_ok && last_cmp && start_ok && end_ok;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. DONE behaves like IDLE for incoming
    // strobes so a new load can start in the result cycle itself; it also
    // clears the per-job counters and the overflow flag.
    always_comb begin
        state_d   = state_q;
        str_start = 1'b0;
        str_wr    = 1'b0;
        pat_start = 1'b0;
        pat_wr    = 1'b0;
        k_inc     = 1'b0;
        p_adv     = 1'b0;
        rec       = 1'b0;
        job_clr   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                job_clr = (state_q == DONE);
                if (bus.isstring) begin
                    str_start = 1'b1;
                    state_d   = LOAD_STR;
                end else if (bus.ispattern) begin
                    pat_start = 1'b1;
                    state_d   = LOAD_PAT;
                end else begin
                    state_d   = IDLE;
                end
            end
            LOAD_STR: begin
                if (bus.isstring) begin
                    str_wr  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_PAT: begin
                if (bus.ispattern) begin
                    pat_wr  = 1'b1;
                end else begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (past_end) begin
                    state_d = DONE;
                end else if (step_ok && !last_cmp) begin
                    k_inc = 1'b1;
                end else begin
                    p_adv = 1'b1;
                    if (hit) begin
                        rec = 1'b1;
                        if (!find_all_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: character storage, lengths, scan counters and results.
    // Writes past the maximum length are dropped but flag overflow; the
    // stored length saturates at the maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STR_MAX; i++) begin
                str[i] <= '0;
            end
            for (int i = 0; i < PAT_MAX; i++) begin
                pat[i] <= '0;
            end
            len        <= '0;
            plen       <= '0;
            p          <= '0;
            k          <= '0;
            count      <= '0;
            first_idx  <= '0;
            overflow_q <= 1'b0;
            find_all_q <= 1'b0;
        end else begin
            if (job_clr) begin
                count      <= '0;
                first_idx  <= '0;
                overflow_q <= 1'b0;
            end

            if (str_start) begin
                str[0] <= bus.chardata;
                len    <= LW'(1);
            end
            if (str_wr) begin
                if (len < LW'(STR_MAX)) begin
                    str[IW'(len)] <= bus.chardata;
                    len           <= len + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            if (pat_start) begin
                pat[0]     <= bus.chardata;
                plen       <= PLW'(1);
                find_all_q <= bus.find_all;
                p          <= '0;
                k          <= '0;
            end
            if (pat_wr) begin
                if (plen < PLW'(PAT_MAX)) begin
                    pat[PW'(plen)] <= bus.chardata;
                    plen           <= plen + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            if (k_inc) begin
                k <= k + 1'b1;
            end
            if (p_adv) begin
                p <= p + 1'b1;
                k <= '0;
            end
            if (rec) begin
                if (count == '0) begin
                    first_idx <= IW'(p);
                end
                if (count != LW'(STR_MAX)) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // Results are only presented in DONE and are zero otherwise, so an
    // asserted reset forces every output low immediately.
    assign bus.valid       = (state_q == DONE);
    assign bus.match       = (state_q == DONE) && (count != '0);
    assign bus.match_index = (state_q == DONE) ? first_idx : '0;
    assign bus.match_count = (state_q == DONE) ? count : '0;
    assign bus.overflow    = (state_q == DONE) && overflow_q;
endmodule

// File: tb/tb_sme_multi.sv
// ---------------------------------------------------------------------------
// tb_sme_multi
// Self-checking bench for sme_multi: a table of directed jobs with
// hand-computed results, followed by a hand-written reset-abort sequence.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sme_multi;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int DATA_W  = 8;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    sme_multi_if #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DATA_W(DATA_W)) bus ();

    sme_multi #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a wait is never satisfied
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string s;
        bit    load_s;
        string pat;
        bit    fa;
        bit    e_match;
        int    e_idx;
        int    e_cnt;
        bit    e_ovf;
        int    max_lat;
    } vec_t;

    function automatic vec_t mk_vec(input string s, input bit load_s, input string pat,
                                    input bit fa, input bit e_match, input int e_idx,
                                    input int e_cnt, input bit e_ovf, input int max_lat);
        vec_t v;
        v.s       = s;
        v.load_s  = load_s;
        v.pat     = pat;
        v.fa      = fa;
        v.e_match = e_match;
        v.e_idx   = e_idx;
        v.e_cnt   = e_cnt;
        v.e_ovf   = e_ovf;
        v.max_lat = max_lat;
        return v;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Streams one job (optional string, then pattern) and checks the result.
    // Called and returning at 1 time unit after a rising edge.
    task automatic apply_stimulus(input vec_t v, input int id);
        string s;
        string pt;
        int    lat;
        bit    seen;
        s  = v.s;
        pt = v.pat;
        if (v.load_s) begin
            for (int i = 0; i < s.len(); i++) begin
                bus.chardata = s[i];
                bus.isstring = 1'b1;
                @(posedge clk); #1;
            end
            bus.isstring = 1'b0;
            @(posedge clk); #1;
        end
        bus.find_all = v.fa;
        for (int i = 0; i < pt.len(); i++) begin
            bus.chardata  = pt[i];
            bus.ispattern = 1'b1;
            @(posedge clk); #1;
        end
        bus.ispattern = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < v.max_lat + 10) begin
            @(posedge clk); #1;
            lat++;
            if (bus.valid) seen = 1'b1;
        end
        check_output($sformatf("v%0d valid_seen", id), int'(seen), 1);
        if (seen) begin
            check_output($sformatf("v%0d latency_within_%0d(lat=%0d)", id, v.max_lat, lat),
                         int'(lat <= v.max_lat), 1);
            check_output($sformatf("v%0d match", id), int'(bus.match), int'(v.e_match));
            check_output($sformatf("v%0d match_index", id), int'(bus.match_index), v.e_idx);
            check_output($sformatf("v%0d match_count", id), int'(bus.match_count), v.e_cnt);
            check_output($sformatf("v%0d overflow", id), int'(bus.overflow), int'(v.e_ovf));
            @(posedge clk); #1;
            check_output($sformatf("v%0d valid_one_cycle", id), int'(bus.valid), 0);
        end
    endtask

    vec_t  vecs[13];
    string long_s;

    initial begin
        int  vcount;
        bit  saw_valid;

        bus.chardata  = '0;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.find_all  = 1'b0;
        rst_n         = 1'b0;

        long_s = "";
        for (int i = 0; i < 40; i++) long_s = {long_s, "b"};

        // Expected values derived by hand from the match rules
        vecs[0]  = mk_vec("",            0, "^$",         0, 1, 0,  1,  0, 3);
        vecs[1]  = mk_vec("hello world", 1, "wor",        0, 1, 6,  1,  0, 29);
        vecs[2]  = mk_vec("ab cab ca",   1, "^ca$",       0, 1, 7,  1,  0, 18);
        vecs[3]  = mk_vec("",            0, "^ab$",       0, 1, 0,  1,  0, 18);
        vecs[4]  = mk_vec("aXaYaZ",      1, "a.",         1, 1, 0,  3,  0, 12);
        vecs[5]  = mk_vec("",            0, "a.$",        1, 1, 4,  1,  0, 12);
        vecs[6]  = mk_vec("ab",          1, "abc",        0, 0, 0,  0,  0, 2);
        vecs[7]  = mk_vec(long_s,        1, ".",          1, 1, 0,  32, 1, 34);
        vecs[8]  = mk_vec("x y",         1, "^",          1, 1, 0,  2,  0, 6);
        vecs[9]  = mk_vec("",            0, "$",          1, 1, 1,  2,  0, 6);
        vecs[10] = mk_vec("abab",        1, "b",          0, 1, 1,  1,  0, 6);
        vecs[11] = mk_vec("aaaaaaaa",    1, "aaaaaaaaaa", 1, 1, 0,  1,  1, 10);
        vecs[12] = mk_vec("abc",         1, "x.",         0, 0, 0,  0,  0, 6);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset valid", int'(bus.valid), 0);
        check_output("reset match", int'(bus.match), 0);
        check_output("reset match_index", int'(bus.match_index), 0);
        check_output("reset match_count", int'(bus.match_count), 0);
        check_output("reset overflow", int'(bus.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vcount = 13;
        for (int i = 0; i < vcount; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Reset asserted in the middle of a long search aborts it
        bus.find_all = 1'b1;
        long_s = "abcdefghijklmnop";
        for (int i = 0; i < long_s.len(); i++) begin
            bus.chardata = long_s[i];
            bus.isstring = 1'b1;
            @(posedge clk); #1;
        end
        bus.isstring = 1'b0;
        @(posedge clk); #1;
        long_s = "zz";
        for (int i = 0; i < long_s.len(); i++) begin
            bus.chardata  = long_s[i];
            bus.ispattern = 1'b1;
            @(posedge clk); #1;
        end
        bus.ispattern = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_output("midreset valid", int'(bus.valid), 0);
        check_output("midreset match", int'(bus.match), 0);
        check_output("midreset match_count", int'(bus.match_count), 0);
        check_output("midreset overflow", int'(bus.overflow), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.valid) saw_valid = 1'b1;
        end
        check_output("midreset no_valid_after_abort", int'(saw_valid), 0);

        // Fresh job after the abort
        apply_stimulus(mk_vec("aa", 1, "a", 0, 1, 0, 1, 0, 4), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
